imem_loader: RTL

- Boot-time program loader and write-side master of the instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into the instruction memory through its write-enable / write-data / address port, at consecutive word indices starting at 0.
- Holds the CPU off while a load is in progress.

---
 rtl/imem_loader.sv | 112 +++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles little-endian 32-bit words from a
// byte stream and writes them to consecutive instruction memory indices from 0.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [63:0]      imem_addr,
  output logic             imem_we,
  output logic [63:0]      imem_wdata,
  output logic             cpu_hold,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_widx;
  logic [1:0]       r_byte;
  logic [31:0]      r_word;
  logic [63:0]      r_addr;
  logic [63:0]      r_wdata;
  logic             r_err;
  logic             w_hs;
  logic             w_last;
  logic             w_zero;
  logic             w_over;

  assign w_hs   = s_valid & s_ready;
  assign w_last = (r_widx == r_count - ONE);
  assign w_zero = (word_count == '0);
  assign w_over = (int'(word_count) > DEPTH);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: if (start) w_next = (w_zero || w_over) ? DONE : RECV;
      RECV:       if (w_hs && r_byte == 2'd3) w_next = WRITE;
      WRITE:      w_next = w_last ? DONE : RECV;
      default:    w_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = (r_state == RECV);
    imem_we  = (r_state == WRITE);
    busy     = (r_state == RECV) || (r_state == WRITE);
    cpu_hold = busy;
    done     = (r_state == DONE);
  end

  // Address/data are captured on the 4th byte so they are already stable
  // when the strobe rises, and they are left untouched until the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_widx  <= '0;
      r_byte  <= '0;
      r_word  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_count <= word_count;
            r_err   <= w_over;
            r_byte  <= '0;
            r_widx  <= '0;
          end
        end
        RECV: begin
          if (w_hs) begin
            r_word[{r_byte, 3'b000} +: 8] <= s_data;
            r_byte <= r_byte + 2'd1;
            if (r_byte == 2'd3) begin
              r_addr  <= {{(64-CNT_W){1'b0}}, r_widx};
              r_wdata <= {32'b0, s_data, r_word[23:0]};
            end
          end
        end
        WRITE: begin
          if (!w_last) r_widx <= r_widx + ONE;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign err        = r_err;

endmodule
